// File: rtl/nios2_debug_jtag_scan_master.sv
// Virtual-JTAG scan initiator for the Nios II debug slave: per command it runs
// UIR, CDR, DR_WIDTH shift phases, UDR and RTI, then returns the captured TDO word.
module nios2_debug_jtag_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int HALF_W = $clog2(TCK_DIV) + 1;
    localparam int BIT_W  = $clog2(DR_WIDTH) + 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5,
        ST_RSP  = 3'd6
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [HALF_W-1:0]     half_cnt_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [DR_WIDTH-1:0]   tx_r;
    logic                  busy_s;
    logic                  half_end_s;
    logic                  rise_s;
    logic                  phase_end_s;
    logic                  last_bit_s;
    logic                  accept_s;

    // A phase ends on the last clk of the tck-high half; sampling happens when tck goes high.
    assign busy_s      = (state_r != ST_IDLE) && (state_r != ST_RSP);
    assign half_end_s  = busy_s && (half_cnt_r == HALF_W'(TCK_DIV - 1));
    assign rise_s      = half_end_s && !vji_tck;
    assign phase_end_s = half_end_s && vji_tck;
    assign last_bit_s  = (bit_cnt_r == BIT_W'(DR_WIDTH - 1));
    assign accept_s    = cmd_valid && cmd_ready;

    // Next-state logic for the scan sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: if (accept_s)    state_next_s = ST_UIR; else state_next_s = ST_IDLE;
            ST_UIR:  if (phase_end_s) state_next_s = ST_CDR; else state_next_s = ST_UIR;
            ST_CDR:  if (phase_end_s) state_next_s = ST_SDR; else state_next_s = ST_CDR;
            ST_SDR: begin
                if (phase_end_s && last_bit_s) begin
                    state_next_s = ST_UDR;
                end else begin
                    state_next_s = ST_SDR;
                end
            end
            ST_UDR:  if (phase_end_s) state_next_s = ST_RTI; else state_next_s = ST_UDR;
            ST_RTI:  if (phase_end_s) state_next_s = ST_RSP; else state_next_s = ST_RTI;
            ST_RSP:  if (rsp_ready)   state_next_s = ST_IDLE; else state_next_s = ST_RSP;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // tck generator: counter parked at zero whenever no scan is in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vji_tck    <= 1'b0;
            half_cnt_r <= {HALF_W{1'b0}};
        end else if (!busy_s) begin
            vji_tck    <= 1'b0;
            half_cnt_r <= {HALF_W{1'b0}};
        end else if (half_end_s) begin
            vji_tck    <= ~vji_tck;
            half_cnt_r <= {HALF_W{1'b0}};
        end else begin
            half_cnt_r <= half_cnt_r + HALF_W'(1);
        end
    end

    // TAP flags and handshake outputs follow the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vji_uir   <= 1'b0;
            vji_cdr   <= 1'b0;
            vji_sdr   <= 1'b0;
            vji_udr   <= 1'b0;
            vji_rti   <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            vji_uir   <= (state_next_s == ST_UIR);
            vji_cdr   <= (state_next_s == ST_CDR);
            vji_sdr   <= (state_next_s == ST_SDR);
            vji_udr   <= (state_next_s == ST_UDR);
            vji_rti   <= (state_next_s == ST_RTI);
            cmd_ready <= (state_next_s == ST_IDLE);
            rsp_valid <= (state_next_s == ST_RSP);
        end
    end

    // Command latch, serial transmit, bit counting and TDO / IR capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_r       <= {DR_WIDTH{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            vji_tdi    <= 1'b0;
            vji_ir_in  <= {IR_WIDTH{1'b0}};
            rsp_data   <= {DR_WIDTH{1'b0}};
            rsp_ir_out <= {IR_WIDTH{1'b0}};
        end else begin
            if (accept_s) begin
                vji_ir_in <= cmd_ir;
                tx_r      <= cmd_data;
            end else if (phase_end_s && (state_next_s == ST_SDR)) begin
                tx_r <= {1'b0, tx_r[DR_WIDTH-1:1]};
            end
            if (phase_end_s) begin
                vji_tdi <= (state_next_s == ST_SDR) ? tx_r[0] : 1'b0;
            end
            // Counter wraps to zero after the last shift so the next scan starts at bit 0.
            if (phase_end_s && (state_r == ST_SDR)) begin
                bit_cnt_r <= last_bit_s ? {BIT_W{1'b0}} : bit_cnt_r + BIT_W'(1);
            end
            if (rise_s && (state_r == ST_UIR)) begin
                rsp_ir_out <= vji_ir_out;
            end
            if (rise_s && (state_r == ST_SDR)) begin
                rsp_data <= {vji_tdo, rsp_data[DR_WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_nios2_debug_jtag_scan_master.sv
// Bench for nios2_debug_jtag_scan_master: table-driven and random scans against a
// simple slave model, plus reset-in-flight and TCK_DIV=1 sequences.
module tb_nios2_debug_jtag_scan_master;

    logic        clk = 1'b0;
    logic        reset_n;
    always #5 clk = ~clk;

    // Default-parameter instance.
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]  cmd_ir, rsp_ir_out, vji_ir_in, vji_ir_out;
    logic [37:0] cmd_data, rsp_data;
    logic        vji_tck, vji_tdi, vji_tdo, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    nios2_debug_jtag_scan_master dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    // Fast-tck instance.
    logic        c1_valid, c1_ready, r1_valid, r1_ready;
    logic [1:0]  c1_ir, r1_ir_out, ir_in1;
    logic [37:0] c1_data, r1_data;
    logic        tck1, tdi1, uir1, cdr1, sdr1, udr1, rti1;
    logic        tdo1 = 1'b1;
    logic [1:0]  ir_out1 = 2'b10;

    nios2_debug_jtag_scan_master #(.DR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_ir(c1_ir), .cmd_data(c1_data),
        .rsp_valid(r1_valid), .rsp_ready(r1_ready), .rsp_data(r1_data), .rsp_ir_out(r1_ir_out),
        .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdo1),
        .vji_ir_in(ir_in1), .vji_ir_out(ir_out1),
        .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1), .vji_rti(rti1)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave model: mode 0 echoes the tdi seen on the previous tck rise,
    // mode 1 captures slave_pat on CDR and shifts it out LSB first.
    logic        slave_mode = 1'b0;
    logic [37:0] slave_pat  = 38'h0;
    logic [37:0] slave_sr   = 38'h0;
    logic        loop_bit   = 1'b0;
    logic        s_tdi, s_cdr, s_sdr;
    assign vji_tdo = slave_mode ? slave_sr[0] : loop_bit;

    always @(posedge vji_tck) begin
        s_tdi = vji_tdi;
        s_cdr = vji_cdr;
        s_sdr = vji_sdr;
        #1;
        loop_bit = s_tdi;
        if (s_cdr) slave_sr = slave_pat;
        else if (s_sdr) slave_sr = {s_tdi, slave_sr[37:1]};
    end

    // Observers.
    logic [4:0] flag_q[$];
    logic [1:0] irin_q[$];
    int onehot_bad = 0;
    int sdr1_rises = 0;
    always @(posedge vji_tck) begin
        flag_q.push_back({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti});
        if (vji_uir) irin_q.push_back(vji_ir_in);
    end
    always @(negedge clk) begin
        if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) > 1) onehot_bad <= onehot_bad + 1;
    end
    always @(posedge tck1) begin
        if (sdr1) sdr1_rises <= sdr1_rises + 1;
    end

    function automatic logic [37:0] ref_rsp(input logic [37:0] d, input logic mode, input logic [37:0] pat);
        logic [37:0] sh;
        sh = d << 1;
        return mode ? pat : sh;
    endfunction

    // Expected tck-rise flag sequence: uir, cdr, 38 x sdr, udr, rti.
    function automatic bit seq_ok();
        logic [4:0] e;
        if (flag_q.size() != 42) return 1'b0;
        for (int i = 0; i < 42; i++) begin
            if (i == 0) e = 5'b10000;
            else if (i == 1) e = 5'b01000;
            else if (i < 40) e = 5'b00100;
            else if (i == 40) e = 5'b00010;
            else e = 5'b00001;
            if (flag_q[i] !== e) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Called at a negedge with the DUT idle; leaves the bench at a negedge after the rsp handshake.
    task automatic do_scan(input logic [37:0] d, input logic [1:0] ir, input logic mode,
                           input logic [37:0] pat, input logic [1:0] iro, input int hold,
                           input logic [37:0] exp_d);
        int n;
        int base;
        bit stable;
        slave_mode = mode;
        slave_pat  = pat;
        vji_ir_out = iro;
        flag_q.delete();
        irin_q.delete();
        base = onehot_bad;
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_ir    = ir;
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", n, 0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 336);
        check("rsp_data", rsp_data, exp_d);
        check("rsp_ir_out", rsp_ir_out, iro);
        check("phase_seq", seq_ok(), 1);
        check("ir_in_uir", (irin_q.size() == 1) && (irin_q[0] === ir), 1);
        check("flags_onehot", onehot_bad - base, 0);
        if (hold > 0) begin
            cmd_valid = 1'b1;
            cmd_data  = ~d;
            cmd_ir    = ~ir;
            stable    = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!rsp_valid || rsp_data !== exp_d || cmd_ready || vji_tck) stable = 1'b0;
            end
            check("hold_stable", stable, 1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("rsp_cleared", rsp_valid, 0);
        check("ready_after_rsp", cmd_ready, 1);
    endtask

    typedef struct {
        logic [37:0] d;
        logic [1:0]  ir;
        logic        mode;
        logic [37:0] pat;
        logic [1:0]  iro;
        int          hold;
        logic [37:0] exp_d;
    } vec_t;

    vec_t vt[6];

    initial begin
        int n;
        int hi;
        int lo;
        int base;
        bit seen;
        logic [63:0] r64;
        logic [37:0] rd;
        logic [37:0] rp;
        logic        rm;

        vt[0] = '{38'h2A_5A5A_5A5A, 2'b01, 1'b0, 38'h0,           2'b00, 0,  38'h14_B4B4_B4B4};
        vt[1] = '{38'h00_1234_5678, 2'b11, 1'b1, 38'h3F_FFFF_FFFF, 2'b10, 0,  38'h3F_FFFF_FFFF};
        vt[2] = '{38'h3F_FFFF_FFFF, 2'b10, 1'b0, 38'h0,           2'b01, 50, 38'h3F_FFFF_FFFE};
        vt[3] = '{38'h20_0000_0001, 2'b00, 1'b1, 38'h15_5555_5555, 2'b11, 0,  38'h15_5555_5555};
        vt[4] = '{38'h00_0000_0000, 2'b01, 1'b1, 38'h20_0000_0001, 2'b01, 3,  38'h20_0000_0001};
        vt[5] = '{38'h20_0000_0001, 2'b11, 1'b0, 38'h0,           2'b00, 0,  38'h00_0000_0002};

        reset_n = 1'b0;
        cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_ir = 2'b00; cmd_data = 38'h0; vji_ir_out = 2'b00;
        c1_valid = 1'b0; r1_ready = 1'b0; c1_ir = 2'b00; c1_data = 38'h0;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_tck_flags", {vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 0);
        check("reset_rsp_data", {rsp_data, rsp_ir_out, vji_ir_in}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_scan(vt[i].d, vt[i].ir, vt[i].mode, vt[i].pat, vt[i].iro, vt[i].hold, vt[i].exp_d);
        end

        for (int i = 0; i < 6; i++) begin
            r64 = {$urandom, $urandom};
            rd  = r64[37:0];
            r64 = {$urandom, $urandom};
            rp  = r64[37:0];
            rm  = 1'($urandom_range(0, 1));
            do_scan(rd, 2'($urandom_range(0, 3)), rm, rp, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 5), ref_rsp(rd, rm, rp));
        end

        // Reset while shifting: scan is dropped, no response appears.
        slave_mode = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = 38'h3F_0F0F_0F0F;
        cmd_ir    = 2'b11;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!vji_sdr && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reach_sdr", vji_sdr, 1);
        repeat (37) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midscan_reset_async", {vji_tck, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, rsp_valid}, 0);
        @(negedge clk);
        check("midscan_reset_ready", cmd_ready, 1);
        check("midscan_reset_outs", {vji_tck, vji_sdr, rsp_valid, rsp_data, vji_ir_in}, 0);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rsp_valid || vji_tck) seen = 1'b1;
        end
        check("no_rsp_after_reset", seen, 0);
        check("idle_after_reset", cmd_ready, 1);

        // TCK_DIV=1 instance: tck toggles every clk, 38 shift rises, response at 84.
        c1_valid = 1'b1;
        c1_data  = 38'h15_5555_5555;
        c1_ir    = 2'b11;
        check("div1_ready", c1_ready, 1);
        base = sdr1_rises;
        @(posedge clk);
        @(negedge clk);
        c1_valid = 1'b0;
        n = 0; hi = 0; lo = 0;
        while (!r1_valid && n < 1000) begin
            if (tck1) hi++; else lo++;
            @(negedge clk);
            n++;
        end
        check("div1_latency", n, 84);
        check("div1_tck_high", hi, 42);
        check("div1_tck_low", lo, 42);
        check("div1_sdr_rises", sdr1_rises - base, 38);
        check("div1_rsp_data", r1_data, 38'h3F_FFFF_FFFF);
        check("div1_rsp_ir_out", r1_ir_out, 2'b10);
        r1_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r1_ready = 1'b0;
        check("div1_done", {r1_valid, c1_ready}, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
